// File: rtl/uart_tx_ctrl.sv
// Transmit sequencer for the APB UART: serialises one frame (start, 5-8 data bits,
// optional parity, 1-2 stop bits) onto txd at a programmable bit period.
module uart_tx_ctrl #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 pclk,
   input  logic                 preset,
   input  logic                 start_tx,
   input  logic [7:0]           tx_data,
   input  logic [4:0]           cfg,
   input  logic [DIV_WIDTH-1:0] baud_div,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   // Parity over only the transmitted data bits; odd_par inverts the even result.
   function automatic logic frame_parity(input logic [7:0] data,
                                         input logic [1:0] len,
                                         input logic       odd_par);
      logic [7:0] mask;
      case (len)
         2'b00:   mask = 8'h1F;
         2'b01:   mask = 8'h3F;
         2'b10:   mask = 8'h7F;
         2'b11:   mask = 8'hFF;
         default: mask = 8'hFF;
      endcase
      return odd_par ^ (^(data & mask));
   endfunction

   state_t                 state_r;
   logic                   start_q_r;
   logic [7:0]             data_r;
   logic [4:0]             cfg_r;
   logic [DIV_WIDTH-1:0]   div_r;
   logic [DIV_WIDTH-1:0]   cnt_r;
   logic [2:0]             bit_idx_r;
   logic                   stop_idx_r;

   logic                   start_edge_s;
   logic                   bit_end_s;
   logic                   last_data_s;

   // Bit-boundary and edge-detect decodes shared by the sequencer.
   always_comb begin
      start_edge_s = start_tx & ~start_q_r;
      bit_end_s    = (cnt_r == DIV_ZERO);
      // Last data index is n-1 = 4 + cfg[1:0].
      last_data_s  = (bit_idx_r == {1'b1, cfg_r[1:0]});
   end

   // Frame sequencer: state, bit timer, shadow registers and registered outputs.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_r    <= ST_IDLE;
         start_q_r  <= 1'b1;
         data_r     <= 8'h00;
         cfg_r      <= 5'b00000;
         div_r      <= DIV_ZERO;
         cnt_r      <= DIV_ZERO;
         bit_idx_r  <= 3'd0;
         stop_idx_r <= 1'b0;
         txd        <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         start_q_r <= start_tx;
         tx_done   <= 1'b0;

         // The timer only counts down to zero, so an all-ones divider never wraps.
         if (state_r != ST_IDLE) begin
            if (bit_end_s) begin
               cnt_r <= div_r;
            end else begin
               cnt_r <= cnt_r - DIV_ONE;
            end
         end

         case (state_r)
            ST_IDLE: begin
               if (start_edge_s) begin
                  data_r  <= tx_data;
                  cfg_r   <= cfg;
                  div_r   <= baud_div;
                  cnt_r   <= baud_div;
                  txd     <= 1'b0;
                  tx_busy <= 1'b1;
                  state_r <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end_s) begin
                  bit_idx_r <= 3'd0;
                  txd       <= data_r[0];
                  state_r   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end_s) begin
                  if (!last_data_s) begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     txd       <= data_r[bit_idx_r + 3'd1];
                  end else if (cfg_r[3]) begin
                     txd     <= frame_parity(data_r, cfg_r[1:0], cfg_r[4]);
                     state_r <= ST_PARITY;
                  end else begin
                     txd        <= 1'b1;
                     stop_idx_r <= 1'b0;
                     state_r    <= ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end_s) begin
                  txd        <= 1'b1;
                  stop_idx_r <= 1'b0;
                  state_r    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_end_s) begin
                  if (stop_idx_r == cfg_r[2]) begin
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                     state_r <= ST_IDLE;
                  end else begin
                     stop_idx_r <= 1'b1;
                  end
               end
            end
            default: begin
               txd     <= 1'b1;
               tx_busy <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: per-cycle {txd,tx_busy,tx_done} expectations are
// queued when a frame is launched and compared on each falling clock edge.
module tb_uart_tx_ctrl;

   logic        pclk;
   logic        preset;
   logic        start_tx;
   logic [7:0]  tx_data;
   logic [4:0]  cfg;
   logic [15:0] baud_div;
   logic        txd;
   logic        tx_busy;
   logic        tx_done;

   int          checks_r = 0;
   int          errors_r = 0;
   logic [2:0]  exp_q[$];
   string       cur_tag = "none";

   uart_tx_ctrl #(.DIV_WIDTH(16)) dut (
      .pclk     (pclk),
      .preset   (preset),
      .start_tx (start_tx),
      .tx_data  (tx_data),
      .cfg      (cfg),
      .baud_div (baud_div),
      .txd      (txd),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_r++;
      if (got !== exp) begin
         errors_r++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected line activity for a whole frame, plus the done pulse and two idle cycles.
   task automatic push_frame(input logic [7:0] d, input logic [4:0] c, input logic [15:0] div);
      logic bits[$];
      int   n;
      logic par;
      n   = 5 + int'(c[1:0]);
      par = c[4];
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         bits.push_back(d[i]);
         par = par ^ d[i];
      end
      if (c[3]) bits.push_back(par);
      bits.push_back(1'b1);
      if (c[2]) bits.push_back(1'b1);
      foreach (bits[k]) begin
         for (int j = 0; j <= int'(div); j++) exp_q.push_back({bits[k], 1'b1, 1'b0});
      end
      exp_q.push_back(3'b101);
      exp_q.push_back(3'b100);
      exp_q.push_back(3'b100);
   endtask

   task automatic send(input logic [7:0] d, input logic [4:0] c, input logic [15:0] div,
                       input bit do_push, input string tag);
      start_tx = 1'b0;
      @(negedge pclk);
      #1;
      tx_data  = d;
      cfg      = c;
      baud_div = div;
      start_tx = 1'b1;
      cur_tag  = tag;
      if (do_push) push_frame(d, c, div);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge pclk);
         n++;
      end
      #1;
      chk({cur_tag, "_drain_left"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   // Scoreboard monitor, sampling away from the active edge.
   always @(negedge pclk) begin
      if (exp_q.size() != 0) begin
         logic [2:0] e;
         e = exp_q.pop_front();
         chk(cur_tag, {29'd0, txd, tx_busy, tx_done}, {29'd0, e});
      end
   end

   initial begin
      preset   = 1'b1;
      start_tx = 1'b1;
      tx_data  = 8'h00;
      cfg      = 5'b00000;
      baud_div = 16'd0;
      repeat (3) @(negedge pclk);
      chk("rst_txd",  {31'd0, txd},     32'd1);
      chk("rst_busy", {31'd0, tx_busy}, 32'd0);
      chk("rst_done", {31'd0, tx_done}, 32'd0);

      // start_tx held high through reset must not launch a frame.
      #1 preset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         chk("held_start", {29'd0, txd, tx_busy, tx_done}, 32'd4);
      end

      send(8'hA5, 5'b00011, 16'd3, 1'b1, "8n1_a5");
      drain(100);
      send(8'h1F, 5'b01100, 16'd0, 1'b1, "5e2_1f");
      drain(50);
      send(8'hD5, 5'b11010, 16'd1, 1'b1, "7o1_d5");
      drain(50);

      // Mid-frame edge and input changes must not disturb the frame in flight.
      send(8'h3C, 5'b00011, 16'd2, 1'b1, "midframe");
      repeat (8) @(negedge pclk);
      #1 start_tx = 1'b0;
      repeat (4) @(negedge pclk);
      #1;
      start_tx = 1'b1;
      tx_data  = 8'h81;
      cfg      = 5'b11111;
      baud_div = 16'd0;
      drain(100);
      send(8'h81, 5'b11111, 16'd0, 1'b1, "newvals");
      drain(50);

      // Reset during DATA: immediate idle outputs, no restart with start_tx still high.
      send(8'hF0, 5'b00011, 16'd1, 1'b0, "rst_mid");
      repeat (5) @(negedge pclk);
      chk("rst_mid_pre", {29'd0, txd, tx_busy, tx_done}, 32'd2);
      #1 preset = 1'b1;
      #1 chk("rst_mid_async", {29'd0, txd, tx_busy, tx_done}, 32'd4);
      repeat (2) @(negedge pclk);
      #1 preset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge pclk);
         chk("rst_mid_after", {29'd0, txd, tx_busy, tx_done}, 32'd4);
      end

      // All-ones divider: start bit must hold without the timer wrapping.
      send(8'h55, 5'b00011, 16'hFFFF, 1'b0, "maxdiv");
      for (int i = 0; i < 3000; i++) exp_q.push_back(3'b010);
      drain(3100);
      #1 preset = 1'b1;
      @(negedge pclk);
      #1 preset = 1'b0;
      start_tx = 1'b0;
      @(negedge pclk);
      chk("final_idle", {29'd0, txd, tx_busy, tx_done}, 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side sequencer for the APB UART. It accepts a start request plus the data byte and frame configuration held in the register block, and serialises one frame onto `txd`: start bit, 5–8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. Bit period is set by a programmable divider. `tx_done` drives the register block's `set_tx_done` status input.

## Interface
Parameters:
- `DIV_WIDTH`, default 16: width of the baud divider input.

Ports:
- `pclk`  in  1  — the block's single clock.
- `preset`  in  1  — asynchronous, active-high reset.
- `start_tx`  in  1  — start request level from the control register. Only its rising edge acts.
- `tx_data`  in  8  — byte to transmit.
- `cfg`  in  5  — frame format:
  - [1:0] data bits: 00=5, 01=6, 10=7, 11=8.
  - [2] stop bits: 0=1, 1=2.
  - [3] parity enable.
  - [4] parity type: 0=even, 1=odd.
- `baud_div`  in  DIV_WIDTH  — cycles per bit minus 1.
- `txd`  out  1  — serial line, idles high.
- `tx_busy`  out  1  — high while a frame is in progress.
- `tx_done`  out  1  — one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Start detection:
  - Registered `start_q` holds the previous `start_tx` sample.
  - A start is accepted only when state=IDLE, `start_tx`=1 and `start_q`=0.
  - A rising edge seen in any other state is dropped. There is no queueing.
- On accept:
  - `tx_data`, `cfg` and `baud_div` are latched into shadow registers.
  - Later changes to these inputs do not affect the frame in flight.
- Bit timer:
  - Counter loads `baud_div` at each bit start and decrements.
  - A bit ends when the counter reaches 0, so each bit lasts `baud_div`+1 cycles.
  - `baud_div`=0 gives 1-cycle bits.
- Data bits: count n = 5 + cfg[1:0]. Sent as shadow bit 0 first up to bit n−1. Bits above n−1 are ignored.
- Parity bit: XOR of the n transmitted data bits, inverted when cfg[4]=1. Sent only when cfg[3]=1.
- Transitions:
  - IDLE→START on accept.
  - START→DATA at bit end.
  - DATA→PARITY after the n-th data bit if parity is enabled, else DATA→STOP.
  - PARITY→STOP at bit end.
  - STOP→IDLE after 1 or 2 stop-bit periods.
- Frame length in cycles: (1 + n + cfg[3] + 1 + cfg[2]) × (`baud_div`+1).

## Timing
- All outputs are registered.
- Reset values:
  - `txd`=1, `tx_busy`=0, `tx_done`=0.
  - State=IDLE, `start_q`=1, counters=0.
- Because `start_q` resets to 1, a `start_tx` held high through reset does not start a frame.
- Latency: when the accepting edge is sampled at clock edge E, `txd`=0 and `tx_busy`=1 from E onward. `txd` changes only on bit boundaries.
- Frame end:
  - At the clock edge ending the last stop bit, `tx_busy`→0 and `tx_done`→1 for exactly one cycle.
  - `txd` stays 1.
- The earliest next accept is the cycle after `tx_busy` falls, and it needs a fresh 0→1 on `start_tx`.
- If the start edge coincides with the frame-end cycle, the state is still STOP, so the edge is dropped.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronously).
  - No `tx_done` pulse is produced.
  - The partial frame is abandoned.
- `baud_div` of all ones is legal. The counter must not wrap or overflow.

## Test plan
- **8N1, 0xA5.** cfg=5'b00011, `baud_div`=3, one rising edge on `start_tx`.
  - `txd` bit sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - `tx_busy` high for 40 cycles.
  - `tx_done` is a single pulse at the 40th edge.
- **5 data bits, even parity, 2 stop.** 0x1F, cfg=5'b01100, `baud_div`=0.
  - 9-cycle frame: 0,1,1,1,1,1,1,1,1.
  - The parity bit is 1.
- **7 data bits, odd parity, 1 stop.** 0xD5 (bit 7 must be ignored), cfg=5'b11010, `baud_div`=1.
  - Data bits 1,0,1,0,1,0,1, then parity 1.
  - 20-cycle frame.
- **Mid-frame input changes.**
  - Toggle `start_tx` 0→1 again and change `tx_data`, `cfg` and `baud_div` during the frame.
  - The frame is unchanged, with no second frame.
  - A fresh edge after `tx_done` starts the new frame using the new values.
- **Reset mid-frame.** Assert `preset` during the DATA state.
  - `txd`=1 and `tx_busy`=0 immediately, with no `tx_done`.
  - After release with `start_tx` held at 1, no frame starts.
- **Maximum divider.** `baud_div`=16'hFFFF, 8N1.
  - Each bit lasts 65536 cycles.
  - `tx_done` at cycle 655360.
